// File: rtl/sd_cmd_deserializer_pkg.sv
// Shared types and constants for the SD CMD-line deserializer (package sd_pkg).
package sd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_SHIFT,
    ST_HOLD
  } sd_deser_state_t;

  localparam logic [6:0]  SD_CRC7_POLY   = 7'h09;
  localparam int unsigned SD_FRAME_SHORT = 48;
  localparam int unsigned SD_FRAME_LONG  = 136;

  // One serial CRC7 step, MSB of the register is the outgoing remainder bit.
  function automatic logic [6:0] sd_crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_deserializer_if.sv
// Handshake/data bundle between the CMD pad sampler, the deserializer and the cmd controller.
interface sd_cmd_deserializer_if #(
  parameter int unsigned BITS         = 136,
  parameter int unsigned BITS_COUNTER = 8
);
  logic                    enable;
  logic                    start;
  logic [BITS_COUNTER-1:0] framesize;
  logic                    crc_skip;
  logic                    in;
  logic [BITS-1:0]         out;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;
  logic                    timeout;
  logic                    end_err;
  logic                    crc_err;

  modport master (
    output enable, start, framesize, crc_skip, in, out_ready,
    input  out, out_valid, busy, timeout, end_err, crc_err
  );

  modport slave (
    input  enable, start, framesize, crc_skip, in, out_ready,
    output out, out_valid, busy, timeout, end_err, crc_err
  );
endinterface

// File: rtl/sd_cmd_deserializer_crc7.sv
// Serial CRC7 (x^7+x^3+1, seed 0) with synchronous clear and bit enable.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_crc <= '0;
    end else if (i_clear) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= sd_crc7_step(r_crc, i_bit);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/sd_cmd_deserializer.sv
// SD CMD-line serial-to-parallel receiver with start-bit timeout and end/CRC7 checks.
// Optional CRC7 checking is compiled in with `define SD_DESER_CRC7_EN.
module sd_cmd_deserializer
  import sd_pkg::*;
#(
  parameter int unsigned BITS         = 136,
  parameter int unsigned BITS_COUNTER = 8,
  parameter int unsigned MSB_FIRST    = 1,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned TIMEOUT_BITS = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  sd_cmd_deserializer_if.slave  bus
);

  localparam logic [BITS_COUNTER-1:0] LP_BITS       = BITS_COUNTER'(BITS);
  localparam logic [BITS_COUNTER-1:0] LP_MIN        = BITS_COUNTER'(2);
  localparam logic [TIMEOUT_BITS-1:0] LP_TIMER_LAST = TIMEOUT_BITS'(TIMEOUT - 1);

  sd_deser_state_t           r_state;
  logic [BITS-1:0]           r_out;
  logic [BITS_COUNTER-1:0]   r_cnt;
  logic [BITS_COUNTER-1:0]   r_fsize;
  logic [TIMEOUT_BITS-1:0]   r_timer;
  logic                      r_valid;
  logic                      r_busy;
  logic                      r_timeout;
  logic                      r_end_err;

  logic [BITS_COUNTER-1:0]   w_fsize_clamped;
  logic [BITS_COUNTER-1:0]   w_cnt_nxt;
  logic                      w_start_acc;

  assign w_fsize_clamped = (bus.framesize < LP_MIN || bus.framesize > LP_BITS) ? LP_BITS
                                                                              : bus.framesize;
  assign w_cnt_nxt   = r_cnt + BITS_COUNTER'(1);
  assign w_start_acc = (r_state == ST_IDLE) && bus.enable && bus.start;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_out     <= '0;
      r_cnt     <= '0;
      r_fsize   <= '0;
      r_timer   <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_end_err <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_acc) begin
            r_fsize   <= w_fsize_clamped;
            r_out     <= '0;
            r_timer   <= '0;
            r_cnt     <= '0;
            r_end_err <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_WAIT_START;
          end
        end
        ST_WAIT_START: begin
          if (bus.enable) begin
            // The start bit is 0 and r_out was just cleared, so capturing it leaves r_out unchanged.
            if (!bus.in) begin
              r_cnt   <= BITS_COUNTER'(1);
              r_state <= ST_SHIFT;
            end else if (r_timer == LP_TIMER_LAST) begin
              r_timeout <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= ST_IDLE;
            end else begin
              r_timer <= r_timer + TIMEOUT_BITS'(1);
            end
          end
        end
        ST_SHIFT: begin
          if (bus.enable) begin
            if (MSB_FIRST != 0) begin
              r_out <= {r_out[BITS-2:0], bus.in};
            end else begin
              r_out[r_cnt] <= bus.in;
            end
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_fsize) begin
              r_end_err <= ~bus.in;
              r_valid   <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_valid;
  assign bus.busy      = r_busy;
  assign bus.timeout   = r_timeout;
  assign bus.end_err   = r_end_err;

`ifdef SD_DESER_CRC7_EN
  localparam logic [BITS_COUNTER:0] LP_C2 = (BITS_COUNTER+1)'(2);
  localparam logic [BITS_COUNTER:0] LP_C8 = (BITS_COUNTER+1)'(8);
  localparam logic [BITS_COUNTER:0] LP_C9 = (BITS_COUNTER+1)'(9);

  logic                    r_skip;
  logic [6:0]              r_rx_crc;
  logic                    r_crc_err;
  logic [6:0]              w_crc;
  logic                    w_cap;
  logic                    w_crc_en;
  logic                    w_rx_en;
  logic                    w_last_cap;
  logic [BITS_COUNTER:0]   w_idx_x;
  logic [BITS_COUNTER:0]   w_fs_x;
  logic [BITS_COUNTER:0]   w_lo;

  // Index of the bit being captured this cycle; the start bit is index 0.
  assign w_idx_x    = (r_state == ST_SHIFT) ? {1'b0, r_cnt} : '0;
  assign w_fs_x     = {1'b0, r_fsize};
  assign w_lo       = r_skip ? LP_C8 : '0;
  assign w_cap      = bus.enable && (((r_state == ST_WAIT_START) && !bus.in) ||
                                     (r_state == ST_SHIFT));
  assign w_crc_en   = w_cap && (w_idx_x >= w_lo) && ((w_idx_x + LP_C9) <= w_fs_x);
  assign w_rx_en    = w_cap && ((w_idx_x + LP_C8) >= w_fs_x) && ((w_idx_x + LP_C2) <= w_fs_x);
  assign w_last_cap = (r_state == ST_SHIFT) && bus.enable && (w_cnt_nxt == r_fsize);

  sd_crc7 u_crc7 (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_start_acc),
    .i_en    (w_crc_en),
    .i_bit   (bus.in),
    .o_crc   (w_crc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_skip    <= 1'b0;
      r_rx_crc  <= '0;
      r_crc_err <= 1'b0;
    end else if (w_start_acc) begin
      r_skip    <= bus.crc_skip;
      r_rx_crc  <= '0;
      r_crc_err <= 1'b0;
    end else begin
      if (w_rx_en) begin
        r_rx_crc <= {r_rx_crc[5:0], bus.in};
      end
      if (w_last_cap) begin
        r_crc_err <= (w_crc != r_rx_crc);
      end
    end
  end

  assign bus.crc_err = r_crc_err;
`else
  assign bus.crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_deserializer.sv
// Self-checking bench: MSB-first and LSB-first instances driven with identical stimulus.
module tb_sd_cmd_deserializer;
  import sd_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       t_enable = 1'b0, t_start = 1'b0, t_skip = 1'b0, t_in = 1'b1, t_ready = 1'b0;
  logic [7:0] t_fs = '0;
  int unsigned checks = 0, errors = 0;
  bit          tgl = 1'b0;

  sd_cmd_deserializer_if #(.BITS(136), .BITS_COUNTER(8)) if_m ();
  sd_cmd_deserializer_if #(.BITS(136), .BITS_COUNTER(8)) if_l ();

  assign if_m.enable = t_enable;  assign if_l.enable = t_enable;
  assign if_m.start  = t_start;   assign if_l.start  = t_start;
  assign if_m.framesize = t_fs;   assign if_l.framesize = t_fs;
  assign if_m.crc_skip = t_skip;  assign if_l.crc_skip = t_skip;
  assign if_m.in = t_in;          assign if_l.in = t_in;
  assign if_m.out_ready = t_ready; assign if_l.out_ready = t_ready;

  sd_cmd_deserializer #(.BITS(136), .BITS_COUNTER(8), .MSB_FIRST(1), .TIMEOUT(64),
                        .TIMEOUT_BITS(7)) dut_m (.clk(clk), .reset(reset), .bus(if_m));
  sd_cmd_deserializer #(.BITS(136), .BITS_COUNTER(8), .MSB_FIRST(0), .TIMEOUT(64),
                        .TIMEOUT_BITS(7)) dut_l (.clk(clk), .reset(reset), .bus(if_l));

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [135:0] frame;   // MSB view: first transmitted bit at [fs-1]
    logic [7:0]   fs;
    logic         skip;
    int unsigned  pre;
    int unsigned  stall;   // 0 none, 1 alternate, 2 random
    int unsigned  hold;
    logic [135:0] exp_out;
    logic         exp_end;
    logic         exp_crc;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Remainder of M(x)*x^7 divided by x^7+x^3+1, message bits lo..hi in transmit order.
  function automatic logic [6:0] crc7_ref(input logic [135:0] b, input int lo, input int hi);
    logic [7:0] r;
    logic       nb;
    r = '0;
    for (int k = lo; k <= hi + 7; k++) begin
      nb = 1'b0;
      if (k <= hi) nb = b[k];
      r = {r[6:0], nb};
      if (r[7]) r = r ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic int unsigned clamp_fs(input logic [7:0] fs);
    return (fs < 2 || fs > 136) ? 136 : int'(fs);
  endfunction

  function automatic logic [135:0] to_tx(input logic [135:0] v, input int unsigned fs);
    logic [135:0] b;
    b = '0;
    for (int unsigned k = 0; k < fs; k++) b[k] = v[fs-1-k];
    return b;
  endfunction

  function automatic logic model_crc_err(input logic [135:0] b, input int unsigned fs,
                                         input logic skip);
`ifdef SD_DESER_CRC7_EN
    logic [6:0] rx;
    for (int unsigned j = 0; j < 7; j++) rx[6-j] = b[fs-8+j];
    return crc7_ref(b, skip ? 8 : 0, int'(fs) - 9) != rx;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_m"}, if_m.out, '0);
    chk({tag, "_out_l"}, if_l.out, '0);
    chk({tag, "_valid"}, {if_m.out_valid, if_l.out_valid}, '0);
    chk({tag, "_busy"}, {if_m.busy, if_l.busy}, '0);
    chk({tag, "_timeout"}, {if_m.timeout, if_l.timeout}, '0);
    chk({tag, "_errs"}, {if_m.end_err, if_l.end_err, if_m.crc_err, if_l.crc_err}, '0);
  endtask

  task automatic start_frame(input logic [7:0] fs, input logic skip);
    t_fs = fs; t_skip = skip; t_start = 1'b1; t_enable = 1'b1; t_in = 1'b1; t_ready = 1'b0;
    tick();
    t_start = 1'b0;
    chk("busy_after_start", {if_m.busy, if_l.busy}, 2'b11);
  endtask

  task automatic feed(input logic [135:0] b, input int unsigned n, input int unsigned stall);
    int unsigned k, guard;
    logic en;
    k = 0; guard = 0;
    while (k < n && guard < 4096) begin
      en = (stall == 0) ? 1'b1 : (stall == 1) ? tgl : 1'($urandom);
      tgl = ~tgl;
      t_enable = en;
      t_in = en ? b[k] : 1'($urandom);
      tick();
      if (en) k++;
      guard++;
    end
    if (k < n) begin
      errors++;
      $display("FAIL feed_budget: got %0d bits expected %0d", k, n);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int unsigned  fse;
    logic [135:0] b, exp_l;
    fse = clamp_fs(v.fs);
    b = to_tx(v.frame, fse);
    exp_l = '0;
    for (int unsigned k = 0; k < fse; k++) exp_l[k] = v.exp_out[fse-1-k];
    start_frame(v.fs, v.skip);
    for (int unsigned i = 0; i < v.pre; i++) begin
      t_enable = 1'b1; t_in = 1'b1; tick();
    end
    feed(b, fse, v.stall);
    chk({tag, "_valid"}, {if_m.out_valid, if_l.out_valid}, 2'b11);
    chk({tag, "_out_m"}, if_m.out, v.exp_out);
    chk({tag, "_out_l"}, if_l.out, exp_l);
    chk({tag, "_end_err"}, {if_m.end_err, if_l.end_err}, {2{v.exp_end}});
    chk({tag, "_crc_err"}, {if_m.crc_err, if_l.crc_err}, {2{v.exp_crc}});
    chk({tag, "_busy_hold"}, {if_m.busy, if_l.busy}, 2'b00);
    for (int unsigned i = 0; i < v.hold; i++) begin
      t_enable = 1'($urandom); t_ready = 1'b0; t_start = ~t_start;
      tick();
      chk({tag, "_hold_out"}, if_m.out, v.exp_out);
      chk({tag, "_hold_valid"}, {if_m.out_valid, if_l.out_valid, if_m.busy}, 3'b110);
    end
    t_ready = 1'b1; t_start = 1'b1; t_enable = 1'b1;
    tick();
    t_ready = 1'b0; t_start = 1'b0;
    chk({tag, "_release"}, {if_m.out_valid, if_l.out_valid, if_m.busy, if_l.busy}, 4'b0000);
  endtask

  initial begin
    vec_t         rv;
    logic [135:0] b;
    logic [119:0] pl;
    logic [6:0]   c;
    int unsigned  fse, en_cnt, guard;

    vecs[0] = '{frame: 136'h40_0000_0000_95, fs: 8'd48, skip: 1'b0, pre: 0, stall: 0, hold: 1,
                exp_out: 136'h40_0000_0000_95, exp_end: 1'b0, exp_crc: 1'b0};
    vecs[1] = '{frame: 136'h51_0000_0000_55, fs: 8'd48, skip: 1'b0, pre: 3, stall: 2, hold: 2,
                exp_out: 136'h51_0000_0000_55, exp_end: 1'b0, exp_crc: 1'b0};
    vecs[2] = '{frame: 136'h48_0000_01AA_87, fs: 8'd48, skip: 1'b0, pre: 1, stall: 1, hold: 0,
                exp_out: 136'h48_0000_01AA_87, exp_end: 1'b0, exp_crc: 1'b0};
    b = to_tx({96'h0, 40'h3F_0000_0120}, 40);
    c = crc7_ref(b, 0, 39);
    vecs[3] = '{frame: {88'h0, 40'h3F_0000_0120, c, 1'b1}, fs: 8'd48, skip: 1'b0, pre: 3,
                stall: 0, hold: 10, exp_out: {88'h0, 40'h3F_0000_0120, c, 1'b1},
                exp_end: 1'b0, exp_crc: 1'b0};
    vecs[4] = vecs[3];
    vecs[4].stall = 1;
    vecs[4].hold = 1;
`ifdef SD_DESER_CRC7_EN
    vecs[5] = '{frame: 136'h40_0000_0100_94, fs: 8'd48, skip: 1'b0, pre: 0, stall: 0, hold: 1,
                exp_out: 136'h40_0000_0100_94, exp_end: 1'b1, exp_crc: 1'b1};
`else
    vecs[5] = '{frame: 136'h40_0000_0100_94, fs: 8'd48, skip: 1'b0, pre: 0, stall: 0, hold: 1,
                exp_out: 136'h40_0000_0100_94, exp_end: 1'b1, exp_crc: 1'b0};
`endif
    pl = {64'h0123_4567_89AB_CDEF, 56'hFEDC_BA98_7654_32};
    vecs[6] = '{frame: {8'h3F, pl, 7'h00, 1'b1}, fs: 8'd0, skip: 1'b1, pre: 2, stall: 0, hold: 1,
                exp_out: {8'h3F, pl, 7'h00, 1'b1}, exp_end: 1'b0, exp_crc: 1'b0};
    vecs[6].exp_crc = model_crc_err(to_tx(vecs[6].frame, 136), 136, 1'b1);

    tick(); tick();
    check_reset_state("reset");
    reset = 1'b1;
    tick();

    for (int unsigned i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Start bit never arrives: timer counts only enabled cycles.
    start_frame(8'd48, 1'b0);
    en_cnt = 0; guard = 0;
    t_in = 1'b1;
    while (en_cnt < 64 && guard < 1000) begin
      t_enable = 1'($urandom);
      tick();
      if (t_enable) en_cnt++;
      guard++;
      chk("timeout_pulse", {if_m.timeout, if_l.timeout}, {2{t_enable && en_cnt == 64}});
      chk("timeout_busy", {if_m.busy, if_l.busy}, {2{en_cnt < 64}});
    end
    chk("timeout_budget", 136'(en_cnt), 136'd64);
    t_enable = 1'b1;
    tick();
    chk("timeout_after", {if_m.timeout, if_l.timeout, if_m.out_valid, if_l.out_valid}, 4'b0000);

    // Reset 20 bits into a 136-bit crc_skip frame, then a clean frame.
    rv = vecs[6];
    rv.fs = 8'd136;
    start_frame(8'd136, 1'b1);
    feed(to_tx(rv.frame, 136), 20, 0);
    reset = 1'b0;
    tick();
    check_reset_state("midreset");
    reset = 1'b1; t_in = 1'b1;
    for (int unsigned i = 0; i < 3; i++) tick();
    check_reset_state("postreset");
    run_vec(rv, "after_reset");

    for (int unsigned r = 0; r < 40; r++) begin
      rv.fs = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(137, 255)) :
                                            8'($urandom_range(9, 136));
      if (r == 5) rv.fs = 8'd1;
      fse = clamp_fs(rv.fs);
      rv.skip = 1'($urandom);
      b = '0;
      for (int unsigned k = 1; k < fse; k++) b[k] = 1'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        c = crc7_ref(b, rv.skip ? 8 : 0, int'(fse) - 9);
        for (int unsigned j = 0; j < 7; j++) b[fse-8+j] = c[6-j];
        b[fse-1] = 1'b1;
      end
      rv.frame = '0;
      for (int unsigned k = 0; k < fse; k++) rv.frame[fse-1-k] = b[k];
      rv.exp_out = rv.frame;
      rv.exp_end = ~b[fse-1];
      rv.exp_crc = model_crc_err(b, fse, rv.skip);
      rv.pre = $urandom_range(0, 5);
      rv.stall = $urandom_range(0, 2);
      rv.hold = $urandom_range(0, 4);
      run_vec(rv, $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
